ap_ins_cache_ctrl: RTL and testbench
====================================

Name: ap_ins_cache_ctrl

Overview:
Sequential instruction-cache controller for the associative processor front end.
- Holds one main window of ISA_DEPTH instructions and one fixed interrupt window of INT_INS_DEPTH instructions.
- Resolves fetch requests as hit or miss; on a miss it runs a DDR burst refill.
- Generalises the previous combinational cache arithmetic into a parametrised lookup/refill FSM with a request/response handshake.

Parameters:
ISA_DEPTH, 128, main window depth in instructions (power of 2, ≤512)
INT_INS_DEPTH, 27, interrupt window depth in instructions (≤512)
OPCODE_WIDTH, 4, opcode field width
ADDR_WIDTH_CAM, 8, CAM address field width
OPRAND_2_WIDTH, 2, operand-2 field width
ADDR_WIDTH_MEM, 16, instruction address width
ISA_WIDTH, OPCODE_WIDTH+ADDR_WIDTH_CAM+OPRAND_2_WIDTH+ADDR_WIDTH_MEM, instruction width
DDR_ADDR_WIDTH, 28, DDR byte address width
DDR_DATA_WIDTH, 64, DDR beat width (≥ISA_WIDTH)
DDR_ADDR_SHIFT, 3, instruction address to DDR address left shift

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  fetch request
req_ready  out  1  controller can accept a request
req_addr  in  ADDR_WIDTH_MEM  instruction address
flush  in  1  invalidate main window
rsp_valid  out  1  one-cycle pulse, instruction valid
rsp_ins  out  ISA_WIDTH  fetched instruction
rsp_hit  out  1  qualifies rsp_valid: 1 = served without refill
rd_burst_req  out  1  DDR burst request, held until the first beat
rd_burst_addr  out  DDR_ADDR_WIDTH  burst start address
rd_burst_len  out  10  burst length in beats
rd_burst_data_valid  in  1  DDR beat valid
rd_burst_data  in  DDR_DATA_WIDTH  DDR beat
load_times  out  10  count of main-window refills, saturates at 1023

Behaviour:
Reset values:
- All outputs 0.
- Both windows invalid; main tag 0; FSM in IDLE.

Region decode:
- INT_BASE = 1 << (ADDR_WIDTH_MEM-1).
- req_addr ≥ INT_BASE selects the interrupt window; tag is fixed at INT_BASE.
- Otherwise the main window is selected; tag is a register.
- off = req_addr - tag, computed at ADDR_WIDTH_MEM bits.

Hit rule:
- Hit when the window is valid and off < depth of that window.
- An interrupt address with off ≥ INT_INS_DEPTH is treated as a main-window miss path using the same refill rules (tag := req_addr, len as for main).

FSM states and transitions:
- IDLE: req_ready=1. On req_valid, capture req_addr and go to LOOKUP.
- LOOKUP: on hit, read storage and go to RESP. On miss, go to REQ.
- REQ, main window:
  - Assert rd_burst_req with rd_burst_addr = req_addr << DDR_ADDR_SHIFT, zero-extended.
  - rd_burst_len = min(ISA_DEPTH, INT_BASE - req_addr), so a main refill never crosses into the interrupt region.
- REQ, interrupt window: addr = INT_BASE << DDR_ADDR_SHIFT, len = INT_INS_DEPTH.
- REQ exits to FILL on the first rd_burst_data_valid; rd_burst_req drops in that same cycle.
- FILL:
  - Each valid beat writes rd_burst_data[ISA_WIDTH-1:0] to entry cnt; cnt increments.
  - The beat with cnt == len-1 ends the fill, updates the tag and sets valid.
  - Main-window fills also increment load_times (saturating).
  - Extra beats arriving after completion are ignored.
  - Then go to LOOKUP; the hit is guaranteed.
- RESP: rsp_valid=1 for one cycle, then go to IDLE.

Latency and rsp_hit:
- Hit: request accepted at cycle N, rsp_valid at N+2.
- Miss: rsp_valid 2 cycles after the last beat.
- rsp_hit=0 for any response preceded by a refill.

Flush:
- In IDLE, flush clears main-window valid next cycle; it has priority over a simultaneous req_valid, which is not accepted that cycle.
- Outside IDLE, flush is latched and applied on entry to IDLE.
- The interrupt window is never flushed.

Reset mid-refill:
- Immediate return to IDLE.
- Both windows invalid.
- rd_burst_req deasserts asynchronously.

Optional Feature:
ICACHE_PERF_CNT_EN
- Defined: adds outputs hit_cnt[31:0], miss_cnt[31:0] and ddr_beat_cnt[31:0].
  - hit_cnt and miss_cnt increment on rsp_valid according to rsp_hit.
  - ddr_beat_cnt increments on every accepted beat.
  - All three wrap and reset to 0.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

Decomposition:
- Package ap_ins_cache_pkg holds:
  - FSM state encoding (IDLE, LOOKUP, REQ, FILL, RESP);
  - INT_BASE and length-clamp helper function;
  - field-width constants shared with the decoder.
- One sub-module, ap_ins_cache_ram: simple dual-port, registered-read, depth ISA_DEPTH+INT_INS_DEPTH.
  - Interrupt entries are mapped at offset ISA_DEPTH.

Test Plan:
- Cold fetch 0x0010 → rd_burst_addr=0x80, len=128; after 128 beats rsp_hit=0 and rsp_ins=beat 0; load_times=1.
- Fetch 0x0011 then 0x008F → hits, rsp_valid 2 cycles after acceptance, no burst.
- Fetch 0x0090 → miss, addr=0x480, len=128, load_times=2.
- Fetch 0x7FC0 → len clamped to 64.
- Fetch 0x8005 → interrupt refill, addr=0x40000, len=27, returns beat 5; then 0x801A hits while the main window stays valid.
- flush asserted during FILL → current response still delivered; the next fetch to the same address misses.
- rst pulsed mid-FILL → rd_burst_req=0 immediately, all outputs 0, the next fetch misses.

Source files
------------

// File: rtl/ap_ins_cache_pkg.sv
// ap_ins_cache_pkg
// Shared definitions for the associative-processor instruction cache:
// FSM state encoding, default instruction field widths (shared with the
// decoder), the interrupt-window base helper and the refill length clamp.
// No ports.
package ap_ins_cache_pkg;

  localparam int IC_OPCODE_WIDTH   = 4;
  localparam int IC_ADDR_WIDTH_CAM = 8;
  localparam int IC_OPRAND_2_WIDTH = 2;
  localparam int IC_ADDR_WIDTH_MEM = 16;
  localparam int IC_ISA_WIDTH      = IC_OPCODE_WIDTH + IC_ADDR_WIDTH_CAM +
                                     IC_OPRAND_2_WIDTH + IC_ADDR_WIDTH_MEM;
  localparam int IC_LEN_WIDTH      = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_REQ    = 3'd2,
    ST_FILL   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Interrupt window starts at the top half of the instruction space.
  function automatic int int_base(input int addr_width);
    return 1 << (addr_width - 1);
  endfunction

  // Main refill length: a full window unless that would run into the
  // interrupt region.
  function automatic logic [IC_LEN_WIDTH-1:0] clamp_len(input logic [31:0] remain,
                                                        input logic [31:0] depth);
    logic [31:0] len;
    len = (remain < depth) ? remain : depth;
    return len[IC_LEN_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/ap_ins_cache_ram.sv
// ap_ins_cache_ram
// Simple dual-port instruction store with registered read.
// Entries [0, ISA_DEPTH) hold the main window, the interrupt window follows.
// Ports:
//   clk, rst          clock, async active-high reset (clears read register)
//   we, waddr, wdata  write port
//   re, raddr         read request; data appears on rdata after the edge
//   rdata             registered read data
module ap_ins_cache_ram #(
  parameter int DEPTH = 155,
  parameter int WIDTH = 30,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ap_ins_cache_ctrl.sv
// ap_ins_cache_ctrl
// Sequential instruction-cache controller: one relocatable main window and
// one fixed interrupt window, hit/miss lookup and DDR burst refill.
// Optional build macro ICACHE_PERF_CNT_EN adds hit/miss/beat counters.
// Ports:
//   clk, rst                          clock, async active-high reset
//   req_valid/req_ready/req_addr      fetch request handshake
//   flush                             invalidate main window
//   rsp_valid/rsp_ins/rsp_hit         one-cycle response
//   rd_burst_req/addr/len             DDR burst request (held to first beat)
//   rd_burst_data_valid/rd_burst_data DDR beats
//   load_times                        saturating main refill count
//   hit_cnt/miss_cnt/ddr_beat_cnt     perf counters (ICACHE_PERF_CNT_EN only)
module ap_ins_cache_ctrl
  import ap_ins_cache_pkg::*;
#(
  parameter int ISA_DEPTH      = 128,
  parameter int INT_INS_DEPTH  = 27,
  parameter int OPCODE_WIDTH   = IC_OPCODE_WIDTH,
  parameter int ADDR_WIDTH_CAM = IC_ADDR_WIDTH_CAM,
  parameter int OPRAND_2_WIDTH = IC_OPRAND_2_WIDTH,
  parameter int ADDR_WIDTH_MEM = IC_ADDR_WIDTH_MEM,
  parameter int ISA_WIDTH      = OPCODE_WIDTH + ADDR_WIDTH_CAM + OPRAND_2_WIDTH + ADDR_WIDTH_MEM,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 64,
  parameter int DDR_ADDR_SHIFT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH_MEM-1:0] req_addr,
  input  logic                      flush,
  output logic                      rsp_valid,
  output logic [ISA_WIDTH-1:0]      rsp_ins,
  output logic                      rsp_hit,
  output logic                      rd_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [9:0]                rd_burst_len,
  input  logic                      rd_burst_data_valid,
  input  logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
  output logic [9:0]                load_times
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]               hit_cnt,
  output logic [31:0]               miss_cnt,
  output logic [31:0]               ddr_beat_cnt
`endif
);

  localparam int AW        = ADDR_WIDTH_MEM;
  localparam int RAM_DEPTH = ISA_DEPTH + INT_INS_DEPTH;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);
  localparam logic [AW-1:0] INT_BASE = AW'(int_base(AW));

  state_e                    state_q;
  logic [AW-1:0]             addr_q, tag_q;
  logic                      main_valid_q, int_valid_q, fill_int_q;
  logic                      miss_q, flush_pend_q;
  logic [9:0]                cnt_q, load_times_q, burst_len_q;
  logic                      req_ready_q, rsp_valid_q, rsp_hit_q, burst_req_q;
  logic [DDR_ADDR_WIDTH-1:0] burst_addr_q;

  logic [AW-1:0]     off_main, off_int, remain;
  logic              in_int, int_sel, hit_d;
  logic [9:0]        main_len_d;
  logic              ram_we, ram_re;
  logic [RAM_AW-1:0] ram_waddr, ram_raddr;
  logic              unused_ddr_hi;

  assign off_main   = addr_q - tag_q;
  assign off_int    = addr_q - INT_BASE;
  assign in_int     = addr_q >= INT_BASE;
  // Interrupt addresses beyond the fixed window fall back to the main window.
  assign int_sel    = in_int && (off_int < AW'(INT_INS_DEPTH));
  assign hit_d      = int_sel ? int_valid_q
                              : (main_valid_q && (off_main < AW'(ISA_DEPTH)));
  assign remain     = INT_BASE - addr_q;
  assign main_len_d = clamp_len(32'(remain), 32'(ISA_DEPTH));

  assign ram_re    = (state_q == ST_LOOKUP) && hit_d;
  assign ram_raddr = int_sel ? RAM_AW'(ISA_DEPTH) + RAM_AW'(off_int) : RAM_AW'(off_main);
  assign ram_we    = ((state_q == ST_REQ) || (state_q == ST_FILL)) && rd_burst_data_valid;
  assign ram_waddr = fill_int_q ? RAM_AW'(ISA_DEPTH) + RAM_AW'(cnt_q) : RAM_AW'(cnt_q);

  assign unused_ddr_hi = ^rd_burst_data[DDR_DATA_WIDTH-1:ISA_WIDTH];

  ap_ins_cache_ram #(
    .DEPTH (RAM_DEPTH),
    .WIDTH (ISA_WIDTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (rd_burst_data[ISA_WIDTH-1:0]),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (rsp_ins)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      tag_q        <= '0;
      main_valid_q <= 1'b0;
      int_valid_q  <= 1'b0;
      fill_int_q   <= 1'b0;
      miss_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
      load_times_q <= '0;
      burst_len_q  <= '0;
      burst_addr_q <= '0;
      burst_req_q  <= 1'b0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (flush && (state_q != ST_IDLE)) flush_pend_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (flush) begin
            main_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end else if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            miss_q      <= 1'b0;
            req_ready_q <= 1'b0;
            state_q     <= ST_LOOKUP;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_LOOKUP: begin
          if (hit_d) begin
            rsp_valid_q <= 1'b1;
            rsp_hit_q   <= ~miss_q;
            state_q     <= ST_RESP;
          end else begin
            miss_q      <= 1'b1;
            fill_int_q  <= int_sel;
            cnt_q       <= '0;
            burst_req_q <= 1'b1;
            if (int_sel) begin
              burst_addr_q <= DDR_ADDR_WIDTH'(INT_BASE) << DDR_ADDR_SHIFT;
              burst_len_q  <= 10'(INT_INS_DEPTH);
            end else begin
              burst_addr_q <= DDR_ADDR_WIDTH'(addr_q) << DDR_ADDR_SHIFT;
              burst_len_q  <= main_len_d;
            end
            state_q <= ST_REQ;
          end
        end
        ST_REQ, ST_FILL: begin
          if (rd_burst_data_valid) begin
            burst_req_q <= 1'b0;
            if (cnt_q == burst_len_q - 10'd1) begin
              if (fill_int_q) begin
                int_valid_q <= 1'b1;
              end else begin
                main_valid_q <= 1'b1;
                tag_q        <= addr_q;
                if (load_times_q != 10'h3FF) load_times_q <= load_times_q + 10'd1;
              end
              state_q <= ST_LOOKUP;
            end else begin
              cnt_q   <= cnt_q + 10'd1;
              state_q <= ST_FILL;
            end
          end
        end
        ST_RESP: begin
          // A flush seen while busy takes effect as we return to IDLE.
          if (flush_pend_q || flush) main_valid_q <= 1'b0;
          flush_pend_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_hit       = rsp_hit_q;
  assign rd_burst_req  = burst_req_q;
  assign rd_burst_addr = burst_addr_q;
  assign rd_burst_len  = burst_len_q;
  assign load_times    = load_times_q;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, beat_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (rsp_valid_q) begin
        if (rsp_hit_q) hit_cnt_q  <= hit_cnt_q + 32'd1;
        else           miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if (ram_we) beat_cnt_q <= beat_cnt_q + 32'd1;
    end
  end

  assign hit_cnt      = hit_cnt_q;
  assign miss_cnt     = miss_cnt_q;
  assign ddr_beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_ap_ins_cache_ctrl.sv
// tb_ap_ins_cache_ctrl
// Directed bench for ap_ins_cache_ctrl. Each DDR beat carries, in its low
// instruction bits, the instruction address it refills, so the expected
// rsp_ins of any fetch is simply its own address.
module tb_ap_ins_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic [29:0] rsp_ins;
  logic        rsp_hit;
  logic        rd_burst_req;
  logic [27:0] rd_burst_addr;
  logic [9:0]  rd_burst_len;
  logic        rd_burst_data_valid = 1'b0;
  logic [63:0] rd_burst_data = '0;
  logic [9:0]  load_times;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ap_ins_cache_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_addr            (req_addr),
    .flush               (flush),
    .rsp_valid           (rsp_valid),
    .rsp_ins             (rsp_ins),
    .rsp_hit             (rsp_hit),
    .rd_burst_req        (rd_burst_req),
    .rd_burst_addr       (rd_burst_addr),
    .rd_burst_len        (rd_burst_len),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_data       (rd_burst_data),
    .load_times          (load_times)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat(input logic [27:0] baddr, input int k);
    logic [29:0] lo;
    lo = 30'(baddr >> 3) + 30'(k);
    return {34'h3_FFFF_FFFF, lo};
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("req_ready", 32'(req_ready), 32'd1);
  endtask

  // Issue one fetch and check the whole transaction. For a miss the bench
  // plays DDR; extra=1 sends two stray beats after the burst completes.
  task automatic fetch(input logic [15:0] a, input logic exp_hit,
                       input logic [27:0] exp_baddr, input logic [9:0] exp_len,
                       input logic [9:0] exp_load, input logic flush_mid,
                       input logic extra);
    int n;
    wait_ready();
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_hit) begin
      check_val("hit_no_rsp_n1", 32'(rsp_valid), 32'd0);
      check_val("hit_no_burst", 32'(rd_burst_req), 32'd0);
      @(negedge clk);
    end else begin
      n = 0;
      while (!rd_burst_req && n < 10) begin
        @(negedge clk);
        n++;
      end
      check_val("burst_req", 32'(rd_burst_req), 32'd1);
      check_val("burst_addr", 32'(rd_burst_addr), 32'(exp_baddr));
      check_val("burst_len", 32'(rd_burst_len), 32'(exp_len));
      for (int k = 0; k < int'(exp_len); k++) begin
        rd_burst_data_valid = 1'b1;
        rd_burst_data       = beat(exp_baddr, k);
        flush               = flush_mid && (k == 3);
        @(negedge clk);
        if (k == 0) check_val("burst_req_drop", 32'(rd_burst_req), 32'd0);
      end
      flush               = 1'b0;
      rd_burst_data_valid = extra;
      rd_burst_data       = 64'h3FFF_FFFF;
      check_val("miss_no_rsp_n1", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    check_val("rsp_valid", 32'(rsp_valid), 32'd1);
    check_val("rsp_hit", 32'(rsp_hit), 32'(exp_hit));
    check_val("rsp_ins", 32'(rsp_ins), 32'(a));
    @(negedge clk);
    rd_burst_data_valid = 1'b0;
    check_val("rsp_pulse", 32'(rsp_valid), 32'd0);
    check_val("load_times", 32'(load_times), 32'(exp_load));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_ins", 32'(rsp_ins), 32'd0);
    check_val("rst_burst_req", 32'(rd_burst_req), 32'd0);
    check_val("rst_burst_len", 32'(rd_burst_len), 32'd0);
    check_val("rst_load_times", 32'(load_times), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, hits inside the window, miss just past it (with stray beats).
    fetch(16'h0010, 1'b0, 28'h80,    10'd128, 10'd1, 1'b0, 1'b0);
    fetch(16'h0011, 1'b1, 28'h0,     10'd0,   10'd1, 1'b0, 1'b0);
    fetch(16'h008F, 1'b1, 28'h0,     10'd0,   10'd1, 1'b0, 1'b0);
    fetch(16'h0090, 1'b0, 28'h480,   10'd128, 10'd2, 1'b0, 1'b1);
    fetch(16'h0090, 1'b1, 28'h0,     10'd0,   10'd2, 1'b0, 1'b0);
    // Refill clamped at the interrupt boundary.
    fetch(16'h7FC0, 1'b0, 28'h3FE00, 10'd64,  10'd3, 1'b0, 1'b0);
    // Interrupt window refill, then hits in both windows.
    fetch(16'h8005, 1'b0, 28'h40000, 10'd27,  10'd3, 1'b0, 1'b0);
    fetch(16'h801A, 1'b1, 28'h0,     10'd0,   10'd3, 1'b0, 1'b0);
    fetch(16'h7FC1, 1'b1, 28'h0,     10'd0,   10'd3, 1'b0, 1'b0);
    // Flush during FILL: response still served, next fetch misses.
    fetch(16'h0200, 1'b0, 28'h1000,  10'd128, 10'd4, 1'b1, 1'b0);
    fetch(16'h0200, 1'b0, 28'h1000,  10'd128, 10'd5, 1'b0, 1'b0);
    fetch(16'h8006, 1'b1, 28'h0,     10'd0,   10'd5, 1'b0, 1'b0);

    // Flush in IDLE beats a simultaneous request.
    wait_ready();
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 16'h0200;
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    check_val("flush_prio_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check_val("flush_prio_no_rsp", 32'(rsp_valid), 32'd0);
    check_val("flush_prio_no_burst", 32'(rd_burst_req), 32'd0);
    fetch(16'h0200, 1'b0, 28'h1000,  10'd128, 10'd6, 1'b0, 1'b0);

    // Reset in the middle of a refill.
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 16'h0300;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rstmid_burst_req", 32'(rd_burst_req), 32'd1);
    for (int k = 0; k < 10; k++) begin
      rd_burst_data_valid = 1'b1;
      rd_burst_data       = beat(28'h1800, k);
      @(negedge clk);
    end
    rd_burst_data_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_val("rstmid_burst_req_async", 32'(rd_burst_req), 32'd0);
    check_val("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rstmid_load_times", 32'(load_times), 32'd0);
    check_val("rstmid_burst_addr", 32'(rd_burst_addr), 32'd0);
    check_val("rstmid_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fetch(16'h0300, 1'b0, 28'h1800,  10'd128, 10'd1, 1'b0, 1'b0);
    fetch(16'h8001, 1'b0, 28'h40000, 10'd27,  10'd1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
